psum_accum_writer: RTL

Receiving end of the PE controller's output qualifiers: consumes the delayed `p_valid_output` / `last_chanel_output` beats together with the PE array's partial sums. It accumulates one tile row of partial sums across input-channel passes, requantizes the final sums and queues them to the output-feature-map writer over a valid/ready port. It also converts the controller's `end_conv` into a drained `done` pulse.

---
 rtl/acc_pkg.sv | 34 +++
 rtl/psum_accum_writer_if.sv | 14 +
 rtl/sync_fifo_fwft.sv | 64 ++++++
 rtl/psum_accum_writer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants, FSM encoding and requantizer for the psum accumulator.
// Also used by the IFM/WGT buffer side for common sizing.
package acc_pkg;

   localparam int LANES      = 8;
   localparam int PSUM_W     = 24;
   localparam int ACC_W      = 32;
   localparam int OUT_W      = 8;
   localparam int TILE_LEN   = 16;
   localparam int FIFO_DEPTH = 16;

   localparam logic signed [ACC_W-1:0] Q_MAX = 2**(OUT_W-1) - 1;
   localparam logic signed [ACC_W-1:0] Q_MIN = -(2**(OUT_W-1));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   function automatic logic [OUT_W-1:0] requant(
      input logic signed [ACC_W-1:0] s,
      input logic        [4:0]       sh,
      input logic                    relu
   );
      logic signed [ACC_W-1:0] q;
      q = s >>> sh;
      if (relu && q < 0) q = '0;
      if (q > Q_MAX) q = Q_MAX;
      if (q < Q_MIN) q = Q_MIN;
      return q[OUT_W-1:0];
   endfunction

endpackage

// File: rtl/psum_accum_writer_if.sv
// Valid/ready output port carrying requantized words and their tile index.
interface psum_accum_writer_if #(
   parameter int LANES = 8,
   parameter int OUT_W = 8,
   parameter int IW    = 4
);
   logic                   o_valid;
   logic                   o_ready;
   logic [LANES*OUT_W-1:0] o_data;
   logic [IW-1:0]          o_idx;

   modport master (output o_valid, output o_data, output o_idx, input o_ready);
   modport slave  (input o_valid, input o_data, input o_idx, output o_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with flush and overflow flag.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign count   = cnt_q;
   assign dout    = mem[rptr_q];
   // a pop frees the slot before the push is judged
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign ovf     = push && full && !do_pop && !flush;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_pop)  rptr_d = rptr_q + AW'(1);
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr_q] <= din;
   end
endmodule

// File: rtl/psum_accum_writer.sv
// Accumulates a tile row of partial sums over channel passes, requantizes
// the final pass and queues results to the OFM writer; signals drained done.
module psum_accum_writer
   import acc_pkg::*;
#(
   parameter int LANES      = acc_pkg::LANES,
   parameter int PSUM_W     = acc_pkg::PSUM_W,
   parameter int ACC_W      = acc_pkg::ACC_W,
   parameter int OUT_W      = acc_pkg::OUT_W,
   parameter int TILE_LEN   = acc_pkg::TILE_LEN,
   parameter int FIFO_DEPTH = acc_pkg::FIFO_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_conv,
   input  logic [4:0]              cfg_shift,
   input  logic                    cfg_relu,
   input  logic                    p_valid,
   input  logic                    last_chanel,
   input  logic [LANES*PSUM_W-1:0] psum,
   input  logic                    end_conv,
   psum_accum_writer_if.master     o_if,
   output logic                    done,
   output logic                    err_ovf
);
   localparam int IW = $clog2(TILE_LEN);
   localparam int DW = LANES*OUT_W;
   localparam int AW = LANES*ACC_W;
   localparam int QW = IW + DW;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(TILE_LEN-1);

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d, s1_idx_q, s1_idx_d;
   logic            first_q, first_d, relu_q, relu_d, err_q, err_d;
   logic [4:0]      shift_q, shift_d;
   logic            s1_valid_q, s1_valid_d;
   logic [AW-1:0]   s1_sum_q, s1_sum_d, sum;
   logic [AW-1:0]   acc_mem [TILE_LEN];
   logic            acc_we, beat, pop, full, empty, ovf, drained;
   logic [DW-1:0]   rq;
   logic [QW-1:0]   q_dout;
   logic [CW-1:0]   q_cnt;

   assign beat = p_valid && (state_q == S_RUN) && !start_conv;

   always_comb begin
      sum = '0;
      rq  = '0;
      for (int l = 0; l < LANES; l++) begin
         sum[l*ACC_W +: ACC_W] =
            (first_q ? '0 : acc_mem[idx_q][l*ACC_W +: ACC_W]) +
            ACC_W'(signed'(psum[l*PSUM_W +: PSUM_W]));
         rq[l*OUT_W +: OUT_W] =
            requant(s1_sum_q[l*ACC_W +: ACC_W], shift_q, relu_q);
      end
   end

   sync_fifo_fwft #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (start_conv),
      .push  (s1_valid_q),
      .din   ({s1_idx_q, rq}),
      .pop   (pop),
      .dout  (q_dout),
      .full  (full),
      .empty (empty),
      .count (q_cnt),
      .ovf   (ovf)
   );

   assign o_if.o_valid = !empty;
   assign o_if.o_data  = empty ? '0 : q_dout[DW-1:0];
   assign o_if.o_idx   = empty ? '0 : q_dout[QW-1:DW];
   assign pop          = !empty && o_if.o_ready;
   assign err_ovf      = err_q;
   // drained also covers the cycle in which the final word leaves
   assign drained = !s1_valid_q &&
                    (empty || (q_cnt == CW'(1) && pop));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      first_d    = first_q;
      shift_d    = shift_q;
      relu_d     = relu_q;
      err_d      = err_q | ovf;
      s1_valid_d = 1'b0;
      s1_idx_d   = s1_idx_q;
      s1_sum_d   = s1_sum_q;
      acc_we     = 1'b0;
      done       = 1'b0;
      if (beat) begin
         s1_valid_d = last_chanel;
         s1_idx_d   = idx_q;
         s1_sum_d   = sum;
         acc_we     = !last_chanel;
         if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            first_d = last_chanel;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
      unique case (state_q)
         S_IDLE:  ;
         S_RUN:   if (end_conv) state_d = S_DRAIN;
         S_DRAIN: if (drained) begin
            state_d = S_IDLE;
            done    = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (start_conv) begin
         state_d    = S_RUN;
         idx_d      = '0;
         first_d    = 1'b1;
         shift_d    = cfg_shift;
         relu_d     = cfg_relu;
         err_d      = 1'b0;
         s1_valid_d = 1'b0;
         done       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         first_q    <= 1'b1;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         err_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         s1_sum_q   <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         first_q    <= first_d;
         shift_q    <= shift_d;
         relu_q     <= relu_d;
         err_q      <= err_d;
         s1_valid_q <= s1_valid_d;
         s1_idx_q   <= s1_idx_d;
         s1_sum_q   <= s1_sum_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc_we) acc_mem[idx_q] <= sum;
   end
endmodule
